hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It sits beside the ID stage and consumes the ID-stage source-register usage flags (R1 = rs, R2 = rt), the register numbers, and the EX/MEM destination info. It produces stall, bubble and flush controls, registered forwarding selects for the EX stage, and a halt/drain sequence for syscall. It also keeps saturating stall and flush performance counters.

## Interface

- `CNT_W`, default 32: width of the performance counters.
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID holds a valid instruction.
- `id_r1_used` in 1: the ID instruction reads rs.
- `id_r2_used` in 1: the ID instruction reads rt.
- `id_rs` in 5: ID source register numbers; `id_rt` in 5 likewise.
- `ex_valid`, `ex_reg_write`, `ex_mem_read` in 1 each: status of the EX-stage instruction.
- `ex_rd` in 5: EX destination register.
- `mem_valid`, `mem_reg_write` in 1 each: status of the MEM-stage instruction.
- `mem_rd` in 5: MEM destination register.
- `ex_branch_taken` in 1: branch or jump resolved taken in EX.
- `ex_halt` in 1: syscall-halt in EX.
- `go` in 1: resume pulse.
- `pc_stall`, `if_id_stall` out 1: hold PC and hold IF/ID.
- `id_ex_bubble` out 1: load a NOP into ID/EX.
- `if_id_flush`, `id_ex_flush` out 1: squash those registers.
- `fwd_a_sel`, `fwd_b_sel` out 2: EX operand source. 0 = register file, 1 = MEM/WB, 2 = EX/MEM. Registered.
- `halted` out 1: core parked.
- `stall_cnt`, `flush_cnt` out CNT_W: saturating counters.

## Operation

- **States:** RUN, DRAIN, HALT. Encoding is 2 bits; the value 3 is illegal and recovers to RUN.
- **Dependency definitions:**
  - dep_ex(r) = `ex_valid` & `ex_reg_write` & `ex_rd` == r & r != 0.
  - dep_mem(r) likewise, using the MEM-stage signals.
  - A source is live if `id_valid` and its used-flag is set.
- **Load-use (RUN only):** triggered when `ex_mem_read` & (dep_ex(rs) on a live rs | dep_ex(rt) on a live rt).
  - Combinationally assert `pc_stall`, `if_id_stall` and `id_ex_bubble` for exactly that cycle.
  - The next cycle the load is in MEM and the consumer proceeds with forward select 1.
- **Taken branch (RUN):** `ex_branch_taken` asserts `if_id_flush` and `id_ex_flush` that cycle.
  - Branch has priority over load-use: no stall and no bubble are issued in that cycle.
- **Halt:** `ex_halt` in RUN moves to DRAIN.
  - `ex_halt` has priority over branch and load-use in the same cycle.
  - In the entry cycle and throughout DRAIN: `pc_stall=1`, `if_id_flush=1`, `id_ex_flush=1`.
  - DRAIN lasts exactly 2 cycles, so the halting instruction and its predecessor retire, then moves to HALT.
  - In HALT: `pc_stall=1`, `if_id_stall=1`, `id_ex_bubble=1`, `halted=1`.
  - `go` in HALT moves to RUN on the next edge. `go` is ignored in any other state.
- **Forwarding registers:** update every cycle.
  - If this cycle is a bubble, a flush, or not RUN: load 0.
  - Otherwise, for each live source: EX/MEM = 2 if dep_ex and not `ex_mem_read`; else MEM/WB = 1 if dep_mem; else 0.
  - A non-live source gets 0. Register 0 never forwards.
- **Counters:**
  - `stall_cnt` increments each load-use stall cycle.
  - `flush_cnt` increments each taken-branch flush cycle.
  - Both saturate at all-ones and are not affected by halt.

## Timing

- **Reset values:** state = RUN, `fwd_*_sel` = 0, both counters = 0, `halted` = 0. All combinational outputs are 0 while `rst_n` = 0.
- **Latency:** stall, bubble and flush outputs are Mealy, visible in the same cycle as the cause. `fwd_*_sel` lags by one cycle and is aligned with the instruction's EX cycle.
- **Reset mid-DRAIN or mid-HALT:** return to RUN immediately (asynchronous). Counters clear.
- **Simultaneous events:** `ex_halt` > `ex_branch_taken` > load-use. A stall and a flush never coexist in RUN.

## Structure

- Shared package `hazard_pkg` holds:
  - the state enum {RUN, DRAIN, HALT};
  - forwarding select constants FWD_RF=0, FWD_MEMWB=1, FWD_EXMEM=2.
- Optional sub-module `sat_counter` (width CNT_W, inc input): instantiate it twice.

## Test plan

- **Load-use:** EX = lw $8 (`ex_mem_read=1`, `ex_rd=8`), ID uses rs=8 → one cycle with `pc_stall=if_id_stall=id_ex_bubble=1`. Next cycle, with `mem_rd=8`, `fwd_a_sel` becomes 1 one cycle later. `stall_cnt=1`.
- **ALU forwarding:** EX add writes $5, ID reads rt=5 and rs=5 → no stall; `fwd_a_sel=fwd_b_sel=2` next cycle. Same with `ex_rd=0` → both 0.
- **Unused operand:** ID `id_r2_used=0`, rt=8, EX lw $8 → no stall, `fwd_b_sel=0`.
- **Branch vs load-use:** taken branch and load-use in the same cycle → flushes=1, `pc_stall=0`, `flush_cnt=1`, `stall_cnt` unchanged.
- **Halt sequence:** `ex_halt` → 2 DRAIN cycles with flushes, then `halted=1`. A `go` pulse during DRAIN is ignored. `go` in HALT → RUN, `halted=0` next cycle.
- **Reset and saturation:** `rst_n` low mid-HALT → `halted=0` immediately. With CNT_W=2, 5 load-use stalls → `stall_cnt=3`.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// State encoding and forwarding select codes.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_MEMWB = 2'd1;
    localparam logic [1:0] FWD_EXMEM = 2'd2;

    // A load in EX has no data yet, so only MEM/WB may serve it.
    function automatic logic [1:0] fwd_pick(
        input logic live,
        input logic dep_ex,
        input logic ex_ld,
        input logic dep_mem
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (live && dep_ex && !ex_ld) begin
            sel = FWD_EXMEM;
        end else if (live && dep_mem) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter.
// Holds at all-ones once reached.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count events, sticking at the maximum value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stall, branch flush,
// EX forwarding selects and syscall halt/drain.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             id_r1_used,
    input  logic             id_r2_used,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_valid,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             mem_valid,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_rd,
    input  logic             ex_branch_taken,
    input  logic             ex_halt,
    input  logic             go,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t state, state_nx;
    logic   drain_cnt, drain_nx;
    logic   inc_stall, inc_flush, fwd_ok;

    logic live_rs, live_rt;
    logic dex_rs, dex_rt, dmem_rs, dmem_rt;
    logic load_use;

    assign live_rs = id_valid & id_r1_used;
    assign live_rt = id_valid & id_r2_used;

    assign dex_rs  = ex_valid & ex_reg_write
                   & (ex_rd == id_rs) & (id_rs != 5'd0);
    assign dex_rt  = ex_valid & ex_reg_write
                   & (ex_rd == id_rt) & (id_rt != 5'd0);
    assign dmem_rs = mem_valid & mem_reg_write
                   & (mem_rd == id_rs) & (id_rs != 5'd0);
    assign dmem_rt = mem_valid & mem_reg_write
                   & (mem_rd == id_rt) & (id_rt != 5'd0);

    assign load_use = ex_mem_read
                    & ((live_rs & dex_rs) | (live_rt & dex_rt));

    // State and drain-cycle registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_nx;
            drain_cnt <= drain_nx;
        end
    end

    // Next state and Mealy controls; halt > branch > load-use.
    always_comb begin
        state_nx     = state;
        drain_nx     = 1'b0;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        halted       = 1'b0;
        inc_stall    = 1'b0;
        inc_flush    = 1'b0;
        fwd_ok       = 1'b0;
        case (state)
            RUN: begin
                if (ex_halt) begin
                    state_nx    = DRAIN;
                    pc_stall    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    inc_flush   = 1'b1;
                end else if (load_use) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_bubble = 1'b1;
                    inc_stall    = 1'b1;
                end else begin
                    fwd_ok = 1'b1;
                end
            end
            DRAIN: begin
                pc_stall    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                drain_nx    = ~drain_cnt;
                if (drain_cnt) begin
                    state_nx = HALT;
                end
            end
            HALT: begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
                halted       = 1'b1;
                if (go) begin
                    state_nx = RUN;
                end
            end
            default: begin
                state_nx = RUN;
            end
        endcase
        if (!rst_n) begin
            pc_stall     = 1'b0;
            if_id_stall  = 1'b0;
            id_ex_bubble = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            halted       = 1'b0;
            inc_stall    = 1'b0;
            inc_flush    = 1'b0;
            fwd_ok       = 1'b0;
        end
    end

    // Forwarding selects, aligned with the consumer's EX cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end else if (fwd_ok) begin
            fwd_a_sel <= fwd_pick(live_rs, dex_rs,
                                  ex_mem_read, dmem_rs);
            fwd_b_sel <= fwd_pick(live_rt, dex_rt,
                                  ex_mem_read, dmem_rt);
        end else begin
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_stall),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl with a
// behavioural model of the hazard rules.
module tb_hazard_ctrl;

    localparam int CW   = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, id_r1_used, id_r2_used;
    logic [4:0]    id_rs, id_rt;
    logic          ex_valid, ex_reg_write, ex_mem_read;
    logic [4:0]    ex_rd;
    logic          mem_valid, mem_reg_write;
    logic [4:0]    mem_rd;
    logic          ex_branch_taken, ex_halt, go;
    logic          pc_stall, if_id_stall, id_ex_bubble;
    logic          if_id_flush, id_ex_flush, halted;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_r1_used      (id_r1_used),
        .id_r2_used      (id_r2_used),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .ex_valid        (ex_valid),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .mem_valid       (mem_valid),
        .mem_reg_write   (mem_reg_write),
        .mem_rd          (mem_rd),
        .ex_branch_taken (ex_branch_taken),
        .ex_halt         (ex_halt),
        .go              (go),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .id_ex_bubble    (id_ex_bubble),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .halted          (halted),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    wire [5:0] obs = {pc_stall, if_id_stall, id_ex_bubble,
                      if_id_flush, id_ex_flush, halted};

    // Reference model: 0 = running, 1 = draining, 2 = parked.
    int        m_mode, m_drain, m_fa, m_fb, m_sc, m_fc;
    logic [5:0] e_obs;
    bit        e_lu, e_br;

    function automatic bit dep_ex(logic [4:0] r);
        return ex_valid && ex_reg_write && ex_rd == r && r != 0;
    endfunction

    function automatic bit dep_mem(logic [4:0] r);
        return mem_valid && mem_reg_write && mem_rd == r && r != 0;
    endfunction

    function automatic int src_sel(bit live, logic [4:0] r);
        if (!live) return 0;
        if (dep_ex(r) && !ex_mem_read) return 2;
        if (dep_mem(r)) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_drain = 0;
        m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
    endtask

    task automatic model_comb();
        bit lrs, lrt;
        lrs  = id_valid && id_r1_used;
        lrt  = id_valid && id_r2_used;
        e_lu = ex_mem_read && ((lrs && dep_ex(id_rs)) ||
                               (lrt && dep_ex(id_rt)));
        e_br = ex_branch_taken;
        e_obs = 6'b0;
        if (!rst_n) e_obs = 6'b0;
        else if (m_mode == 1) e_obs = 6'b100110;
        else if (m_mode == 2) e_obs = 6'b111001;
        else if (ex_halt) e_obs = 6'b100110;
        else if (e_br) e_obs = 6'b000110;
        else if (e_lu) e_obs = 6'b111000;
    endtask

    task automatic model_update();
        int nfa, nfb;
        nfa = 0; nfb = 0;
        if (m_mode == 0 && !ex_halt && !e_br && !e_lu) begin
            nfa = src_sel(id_valid && id_r1_used, id_rs);
            nfb = src_sel(id_valid && id_r2_used, id_rt);
        end
        if (m_mode == 0) begin
            if (ex_halt) begin
                m_mode = 1; m_drain = 2;
            end else if (e_br) begin
                if (m_fc < MAXC) m_fc++;
            end else if (e_lu) begin
                if (m_sc < MAXC) m_sc++;
            end
        end else if (m_mode == 1) begin
            m_drain--;
            if (m_drain == 0) m_mode = 2;
        end else if (go) begin
            m_mode = 0;
        end
        m_fa = nfa; m_fb = nfb;
    endtask

    task automatic idle();
        id_valid = 0; id_r1_used = 0; id_r2_used = 0;
        id_rs = 0; id_rt = 0;
        ex_valid = 0; ex_reg_write = 0; ex_mem_read = 0;
        ex_rd = 0;
        mem_valid = 0; mem_reg_write = 0; mem_rd = 0;
        ex_branch_taken = 0; ex_halt = 0; go = 0;
    endtask

    task automatic settle();
        #1;
        model_comb();
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_load_use(logic [4:0] r);
        id_valid = 1; id_r1_used = 1; id_rs = r;
        ex_valid = 1; ex_reg_write = 1; ex_mem_read = 1;
        ex_rd = r;
    endtask

    task automatic test_reset();
        rst_n = 0;
        set_load_use(5'd8);
        ex_branch_taken = 1; ex_halt = 1; go = 1;
        model_reset();
        #2;
        n_checks++;
        if (obs !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_comb: got %b want 000000", obs);
        end
        n_checks++;
        if ({fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt}
            !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: fa=%0d fb=%0d sc=%0d fc=%0d want 0",
                     fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt);
        end
        @(posedge clk);
        #1;
        idle();
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_load_use();
        idle();
        set_load_use(5'd8);
        settle();
        n_checks++;
        if (obs !== 6'b111000) begin
            n_fail++;
            $display("FAIL lu_stall: got %b want 111000", obs);
        end
        adv();
        idle();
        id_valid = 1; id_r1_used = 1; id_rs = 8;
        mem_valid = 1; mem_reg_write = 1; mem_rd = 8;
        settle();
        n_checks++;
        if (obs !== 6'b0 || fwd_a_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL lu_proceed: obs=%b fa=%0d want 000000/0",
                     obs, fwd_a_sel);
        end
        n_checks++;
        if (stall_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL lu_cnt: got %0d want 1", stall_cnt);
        end
        adv();
        n_checks++;
        if (fwd_a_sel !== 2'd1) begin
            n_fail++;
            $display("FAIL lu_fwd: got %0d want 1", fwd_a_sel);
        end
    endtask

    task automatic test_alu_fwd();
        idle();
        ex_valid = 1; ex_reg_write = 1; ex_rd = 5;
        id_valid = 1; id_r1_used = 1; id_r2_used = 1;
        id_rs = 5; id_rt = 5;
        settle();
        n_checks++;
        if (obs !== 6'b0) begin
            n_fail++;
            $display("FAIL alu_nostall: got %b want 000000", obs);
        end
        adv();
        n_checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b1010) begin
            n_fail++;
            $display("FAIL alu_fwd: fa=%0d fb=%0d want 2/2",
                     fwd_a_sel, fwd_b_sel);
        end
        ex_rd = 0; id_rs = 0; id_rt = 0;
        settle();
        adv();
        n_checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
            n_fail++;
            $display("FAIL alu_r0: fa=%0d fb=%0d want 0/0",
                     fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_unused();
        idle();
        ex_valid = 1; ex_reg_write = 1; ex_mem_read = 1;
        ex_rd = 8;
        id_valid = 1; id_r1_used = 1; id_rs = 3;
        id_r2_used = 0; id_rt = 8;
        settle();
        n_checks++;
        if (obs !== 6'b0) begin
            n_fail++;
            $display("FAIL unused_nostall: got %b want 000000", obs);
        end
        adv();
        n_checks++;
        if (fwd_b_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL unused_fwd: got %0d want 0", fwd_b_sel);
        end
    endtask

    task automatic test_branch_vs_lu();
        logic [CW-1:0] sc0;
        idle();
        sc0 = stall_cnt;
        set_load_use(5'd9);
        ex_branch_taken = 1;
        settle();
        n_checks++;
        if (obs !== 6'b000110) begin
            n_fail++;
            $display("FAIL br_prio: got %b want 000110", obs);
        end
        adv();
        idle();
        settle();
        n_checks++;
        if (flush_cnt !== 2'd1 || stall_cnt !== sc0) begin
            n_fail++;
            $display("FAIL br_cnt: fc=%0d sc=%0d want 1/%0d",
                     flush_cnt, stall_cnt, sc0);
        end
    endtask

    task automatic test_halt();
        idle();
        ex_halt = 1;
        set_load_use(5'd4);
        ex_branch_taken = 1;
        settle();
        n_checks++;
        if (obs !== 6'b100110) begin
            n_fail++;
            $display("FAIL halt_entry: got %b want 100110", obs);
        end
        adv();
        idle();
        for (int i = 0; i < 2; i++) begin
            go = (i == 0);
            settle();
            n_checks++;
            if (obs !== 6'b100110) begin
                n_fail++;
                $display("FAIL halt_drain%0d: got %b want 100110",
                         i, obs);
            end
            adv();
        end
        go = 0;
        settle();
        n_checks++;
        if (obs !== 6'b111001) begin
            n_fail++;
            $display("FAIL halt_park: got %b want 111001", obs);
        end
        adv();
        go = 1;
        settle();
        adv();
        go = 0;
        settle();
        n_checks++;
        if (obs !== 6'b0) begin
            n_fail++;
            $display("FAIL halt_resume: got %b want 000000", obs);
        end
        adv();
    endtask

    task automatic test_reset_mid_halt();
        idle();
        ex_halt = 1;
        settle();
        adv();
        idle();
        for (int i = 0; i < 3; i++) begin
            settle();
            adv();
        end
        n_checks++;
        if (halted !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_parked: got %b want 1", halted);
        end
        #2;
        rst_n = 0;
        model_reset();
        #1;
        n_checks++;
        if (obs !== 6'b0 || stall_cnt !== '0 || flush_cnt !== '0)
        begin
            n_fail++;
            $display("FAIL mid_reset: obs=%b sc=%0d fc=%0d want 0",
                     obs, stall_cnt, flush_cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_saturation();
        idle();
        set_load_use(5'd12);
        for (int i = 0; i < 5; i++) begin
            settle();
            adv();
        end
        idle();
        settle();
        n_checks++;
        if (stall_cnt !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_cnt: got %0d want 3", stall_cnt);
        end
        adv();
    endtask

    task automatic test_random();
        logic [9+2*CW:0] got, exp;
        for (int i = 0; i < 600; i++) begin
            id_valid        = ($urandom_range(0, 7) != 0);
            id_r1_used      = $urandom_range(0, 1);
            id_r2_used      = $urandom_range(0, 1);
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_valid        = ($urandom_range(0, 3) != 0);
            ex_reg_write    = $urandom_range(0, 1);
            ex_mem_read     = $urandom_range(0, 1);
            ex_rd           = 5'($urandom_range(0, 3));
            mem_valid       = ($urandom_range(0, 3) != 0);
            mem_reg_write   = $urandom_range(0, 1);
            mem_rd          = 5'($urandom_range(0, 3));
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            ex_halt         = ($urandom_range(0, 29) == 0);
            go              = ($urandom_range(0, 3) == 0);
            settle();
            got = {obs, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt};
            exp = {e_obs, 2'(m_fa), 2'(m_fb),
                   CW'(m_sc), CW'(m_fc)};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rand[%0d]: got %b want %b",
                         i, got, exp);
            end
            adv();
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_alu_fwd();
        test_unused();
        test_branch_vs_lu();
        test_halt();
        test_reset_mid_halt();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
